usb_rx_packet_buffer: RTL and testbench
=======================================

# usb_rx_packet_buffer

Packet buffer directly downstream of the USB receiver. It captures the payload bytes of each DATA packet that follows an OUT token, and commits a packet only when it ends with EOP and no CRC error; bad or overflowing packets are discarded. It presents committed packets, with a last-byte marker, to the Ethernet transmit side through a show-ahead read port.

## Interface
- DEPTH, 64: payload byte storage; power of two, ≥ 8.
- ADDR_W, $clog2(DEPTH): derived; do not override.
- clk  in  1  system clock.
- n_rst  in  1  reset; synchronous, active-low.
- byte_ready  in  1  one-cycle strobe: data_byte valid.
- data_byte  in  8  received byte (PID, payload, CRC16 bytes in order).
- out_token  in  1  one-cycle strobe: OUT token decoded.
- eop_found  in  1  one-cycle strobe: end of packet.
- crc_err  in  1  one-cycle strobe: CRC failure on current packet.
- rd_en  in  1  pop one byte; ignored when pkt_avail=0.
- rd_data  out  8  byte at read pointer (show-ahead).
- rd_last  out  1  rd_data is the final byte of its packet.
- pkt_avail  out  1  committed bytes present.
- pkt_count  out  ADDR_W+1  committed packets not yet fully read.
- overflow  out  1  one-cycle pulse: packet dropped for lack of space.
- pkt_dropped  out  1  one-cycle pulse: packet dropped for CRC error or short length.

## Operation
- Storage: DEPTH×8 data RAM plus DEPTH×1 last-bit array. Pointers wr_ptr, commit_ptr, rd_ptr are ADDR_W+1 bits wide; the MSB distinguishes full from empty. All pointer arithmetic is mod 2^(ADDR_W+1).
- Space: used = wr_ptr − rd_ptr. Full when used == DEPTH.
- FSM states: IDLE, ARMED, PID, RECV, DROP.
  - IDLE: out_token → ARMED. Other inputs are ignored.
  - ARMED: byte_ready → RECV. This first byte is the DATA PID and is discarded; spec_len is set to 0. eop_found → IDLE (handshake packet or empty packet).
  - RECV: byte_ready while not full → write data_byte at wr_ptr, clear its last bit, wr_ptr+1, spec_len+1. byte_ready while full → wr_ptr←commit_ptr, pulse overflow, → DROP. crc_err → wr_ptr←commit_ptr, pulse pkt_dropped, → DROP. eop_found → commit check (below), → IDLE.
  - DROP: ignore bytes; eop_found → IDLE.
  - out_token in any state other than IDLE: roll back wr_ptr←commit_ptr, → ARMED. No drop pulse.
- Commit check on eop_found in RECV, with T = 2 if trimming is enabled, else 0:
  - If spec_len > T: commit_ptr ← commit_ptr + spec_len − T, set the last bit at index commit_ptr + spec_len − T − 1, wr_ptr ← new commit_ptr, pkt_count+1.
  - Otherwise: wr_ptr ← commit_ptr and pulse pkt_dropped.
- Read: rd_data = mem[rd_ptr], rd_last = last[rd_ptr]. rd_en with pkt_avail=1 → rd_ptr+1. If rd_last=1 on that pop, pkt_count−1.
- pkt_avail = (rd_ptr != commit_ptr). Uncommitted bytes are never visible on the read port.
- Reset (n_rst=0 at a clk edge): all pointers 0, pkt_count 0, state IDLE, pkt_avail 0, rd_last 0, overflow 0, pkt_dropped 0. rd_data is 0 after reset (RAM contents are don't-care; rd_data is masked to 0 when !pkt_avail). Reset mid-packet discards everything, including committed data.

## Timing
- All state updates occur on rising clk.
- A byte is written on the edge where byte_ready=1.
- Commit occurs on the eop_found edge. pkt_avail and pkt_count reflect the commit the following cycle.
- overflow and pkt_dropped assert the cycle after the triggering edge, for exactly 1 cycle.
- rd_data/rd_last update the cycle after the rd_en edge. Zero-latency show-ahead otherwise.
- Simultaneous events:
  - crc_err with eop_found → drop, no commit.
  - crc_err with byte_ready → byte not written, drop.
  - byte_ready with rd_en → both act. Fullness uses the pre-edge rd_ptr, so a pop in the same cycle does not free space for that byte.
  - out_token with eop_found → out_token wins.
- Throughput: one write and one read per cycle.

## Configuration
- USB_RXBUF_CRC_TRIM_EN defined: T=2. The two trailing CRC16 bytes are written but excluded from the commit, so stored packets contain payload only. Packets with spec_len ≤ 2 are dropped.
- USB_RXBUF_CRC_TRIM_EN undefined: T=0. CRC bytes are committed as packet data. Packets with spec_len = 0 are dropped.

## Test plan
- Reset, then out_token, bytes C3,11,22,33,AA,BB, eop_found (trim enabled) → pkt_count=1, pops yield 11,22,33 with rd_last=1 on 33, then pkt_avail=0.
- Same packet with crc_err before eop_found → pkt_dropped pulse, pkt_avail stays 0, wr_ptr equals commit_ptr.
- DEPTH=8: commit a 6-byte payload, then start a second packet of 4 bytes with no reads → overflow pulse on the 3rd byte, first packet still reads back intact.
- Pointer wrap: stream 20 packets of 5 payload bytes through DEPTH=8 with concurrent reads → data order preserved, rd_last on every 5th byte, pkt_count never exceeds 1.
- out_token, C3,AA,BB, eop_found (trim enabled) → pkt_dropped, no commit. Same stimulus with trim disabled → 2-byte packet AA,BB committed.
- Reset asserted mid-RECV with one committed packet present → next cycle pkt_avail=0, pkt_count=0, state IDLE.

Source files
------------

// File: rtl/usb_rx_packet_buffer.sv
// usb_rx_packet_buffer
// Packet buffer behind the USB receiver. Captures DATA payload after an OUT
// token and commits it on a clean EOP. Bad, short or overflowing packets are
// rolled back. Committed packets are presented on a show-ahead read port,
// with a last-byte marker on the final byte of each packet.
// Optional feature macro: USB_RXBUF_CRC_TRIM_EN. When defined, the two
// trailing CRC16 bytes are written but left out of the commit.
module usb_rx_packet_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            byte_ready,
    input  logic [7:0]      data_byte,
    input  logic            out_token,
    input  logic            eop_found,
    input  logic            crc_err,
    input  logic            rd_en,
    output logic [7:0]      rd_data,
    output logic            rd_last,
    output logic            pkt_avail,
    output logic [ADDR_W:0] pkt_count,
    output logic            overflow,
    output logic            pkt_dropped
);

    localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W+1)'(DEPTH);
`ifdef USB_RXBUF_CRC_TRIM_EN
    localparam logic [ADDR_W:0]   TRIM    = (ADDR_W+1)'(2);
`else
    localparam logic [ADDR_W:0]   TRIM    = '0;
`endif

    // PID is part of the state set but never entered: the PID byte is
    // consumed by the ARMED -> RECV transition itself.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PID,
        ST_RECV,
        ST_DROP
    } state_t;

    state_t          state;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] commit_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] spec_len;

    logic [7:0]      mem      [DEPTH];
    logic            last_bit [DEPTH];

    logic [ADDR_W:0]   used;
    logic              full;
    logic              abort_pkt;
    logic              in_recv;
    logic              crc_hit;
    logic              eop_hit;
    logic              wr_byte;
    logic              ovf_hit;
    logic              commit_ok;
    logic              short_hit;
    logic              pop;
    logic              pop_last;
    logic [ADDR_W:0]   commit_next;
    logic [ADDR_W-1:0] last_idx;

    // Read port: only committed bytes are ever visible.
    assign pkt_avail = (rd_ptr != commit_ptr);
    assign rd_data   = pkt_avail ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;
    assign rd_last   = pkt_avail ? last_bit[rd_ptr[ADDR_W-1:0]] : 1'b0;

    // Decode this cycle's events from pre-edge state, in priority order.
    always_comb begin
        // NOTE: every signal is assigned on every pass, so no latch can be inferred.
        used        = wr_ptr - rd_ptr;
        full        = (used == DEPTH_P);
        abort_pkt   = out_token && (state != ST_IDLE);
        in_recv     = (state == ST_RECV) && !abort_pkt;
        crc_hit     = in_recv && crc_err;
        eop_hit     = in_recv && !crc_err && eop_found;
        wr_byte     = in_recv && !crc_err && !eop_found && byte_ready && !full;
        ovf_hit     = in_recv && !crc_err && !eop_found && byte_ready && full;
        commit_ok   = eop_hit && (spec_len > TRIM);
        short_hit   = eop_hit && !(spec_len > TRIM);
        commit_next = commit_ptr + spec_len - TRIM;
        last_idx    = commit_next[ADDR_W-1:0] - IDX_ONE;
        pop         = rd_en && pkt_avail;
        pop_last    = pop && rd_last;
    end

    // Payload and last-marker storage writes.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; pointers define validity and rd_data is masked.
        if (wr_byte) begin
            mem[wr_ptr[ADDR_W-1:0]]      <= data_byte;
            last_bit[wr_ptr[ADDR_W-1:0]] <= 1'b0;
        end
        if (commit_ok) begin
            last_bit[last_idx] <= 1'b1;
        end
    end

    // Packet FSM, pointers, packet counter and status pulses.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register updates from pre-edge values.
        if (!n_rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            spec_len    <= '0;
            pkt_count   <= '0;
            overflow    <= 1'b0;
            pkt_dropped <= 1'b0;
        end else begin
            overflow    <= ovf_hit;
            pkt_dropped <= crc_hit | short_hit;

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (commit_ok && !pop_last) begin
                pkt_count <= pkt_count + PTR_ONE;
            end else if (!commit_ok && pop_last) begin
                pkt_count <= pkt_count - PTR_ONE;
            end

            if (abort_pkt) begin
                wr_ptr <= commit_ptr;
                state  <= ST_ARMED;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (out_token) state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (byte_ready) begin
                            spec_len <= '0;
                            state    <= ST_RECV;
                        end else if (eop_found) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_RECV: begin
                        if (crc_hit || ovf_hit) begin
                            wr_ptr <= commit_ptr;
                            state  <= ST_DROP;
                        end else if (eop_hit) begin
                            if (commit_ok) begin
                                commit_ptr <= commit_next;
                                wr_ptr     <= commit_next;
                            end else begin
                                wr_ptr <= commit_ptr;
                            end
                            state <= ST_IDLE;
                        end else if (wr_byte) begin
                            wr_ptr   <= wr_ptr + PTR_ONE;
                            spec_len <= spec_len + PTR_ONE;
                        end
                    end
                    ST_DROP: begin
                        if (eop_found) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// Testbench for usb_rx_packet_buffer (DEPTH=8). Honours USB_RXBUF_CRC_TRIM_EN.
module tb_usb_rx_packet_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);
`ifdef USB_RXBUF_CRC_TRIM_EN
    localparam int T = 2;
`else
    localparam int T = 0;
`endif
    localparam bit TZ = (T == 0);

    logic          clk;
    logic          n_rst;
    logic          byte_ready;
    logic [7:0]    data_byte;
    logic          out_token;
    logic          eop_found;
    logic          crc_err;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_last;
    logic          pkt_avail;
    logic [AW:0]   pkt_count;
    logic          overflow;
    logic          pkt_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    usb_rx_packet_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .byte_ready  (byte_ready),
        .data_byte   (data_byte),
        .out_token   (out_token),
        .eop_found   (eop_found),
        .crc_err     (crc_err),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .pkt_avail   (pkt_avail),
        .pkt_count   (pkt_count),
        .overflow    (overflow),
        .pkt_dropped (pkt_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (queues of bytes) ----------------
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } entry_t;

    typedef enum {M_IDLE, M_ARMED, M_RECV, M_DROP} mstate_t;

    entry_t     m_committed[$];
    logic [7:0] m_pending[$];
    mstate_t    m_state = M_IDLE;
    logic       m_ovf   = 1'b0;
    logic       m_drop  = 1'b0;

    task automatic model_edge(input logic rst_i, input logic tok, input logic br,
                              input logic [7:0] db, input logic eop, input logic crc,
                              input logic rd);
        int used;
        int keep;
        used   = m_committed.size() + m_pending.size();
        m_ovf  = 1'b0;
        m_drop = 1'b0;
        if (!rst_i) begin
            m_committed.delete();
            m_pending.delete();
            m_state = M_IDLE;
            return;
        end
        if (rd && m_committed.size() > 0) void'(m_committed.pop_front());
        if (tok && m_state != M_IDLE) begin
            m_pending.delete();
            m_state = M_ARMED;
        end else begin
            case (m_state)
                M_IDLE:  if (tok) m_state = M_ARMED;
                M_ARMED: begin
                    if (br) m_state = M_RECV;
                    else if (eop) m_state = M_IDLE;
                end
                M_RECV: begin
                    if (crc) begin
                        m_pending.delete();
                        m_drop  = 1'b1;
                        m_state = M_DROP;
                    end else if (eop) begin
                        keep = m_pending.size() - T;
                        if (keep > 0) begin
                            for (int i = 0; i < keep; i++)
                                m_committed.push_back('{data: m_pending[i], last: (i == keep - 1)});
                        end else begin
                            m_drop = 1'b1;
                        end
                        m_pending.delete();
                        m_state = M_IDLE;
                    end else if (br) begin
                        if (used == DEPTH) begin
                            m_pending.delete();
                            m_ovf   = 1'b1;
                            m_state = M_DROP;
                        end else begin
                            m_pending.push_back(db);
                        end
                    end
                end
                M_DROP: if (eop) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic       e_avail;
        logic [7:0] e_data;
        logic       e_last;
        int         e_count;
        e_avail = (m_committed.size() > 0);
        e_data  = e_avail ? m_committed[0].data : 8'h00;
        e_last  = e_avail ? m_committed[0].last : 1'b0;
        e_count = 0;
        foreach (m_committed[i]) if (m_committed[i].last) e_count++;
        check({tag, ".avail"}, 32'(pkt_avail), 32'(e_avail));
        check({tag, ".data"},  32'(rd_data),   32'(e_data));
        check({tag, ".last"},  32'(rd_last),   32'(e_last));
        check({tag, ".count"}, 32'(pkt_count), 32'(e_count));
        check({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        check({tag, ".drop"},  32'(pkt_dropped), 32'(m_drop));
    endtask

    // One clock: drive inputs, advance model on the edge, settle 1 time unit.
    task automatic step(input logic rst_i, input logic tok, input logic br,
                        input logic [7:0] db, input logic eop, input logic crc,
                        input logic rd);
        n_rst      = rst_i;
        out_token  = tok;
        byte_ready = br;
        data_byte  = db;
        eop_found  = eop;
        crc_err    = crc;
        rd_en      = rd;
        @(posedge clk);
        model_edge(rst_i, tok, br, db, eop, crc, rd);
        #1;
    endtask

    string cur_tag = "init";

    task automatic drv(input logic tok, input logic br, input logic [7:0] db,
                       input logic eop, input logic crc, input logic rd);
        step(1'b1, tok, br, db, eop, crc, rd);
        check_model(cur_tag);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_model(cur_tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst_i, tok, br;
        logic [7:0] db;
        logic       eop, crc, rd;
        logic       e_avail;
        logic [3:0] e_count;
        logic [7:0] e_data;
        logic       e_last, e_ovf, e_drop;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst_i, input logic tok, input logic br,
                                input logic [7:0] db, input logic eop, input logic crc,
                                input logic rd, input logic ea, input logic [3:0] ec,
                                input logic [7:0] ed, input logic el, input logic eo,
                                input logic edr);
        vec_t v;
        v.rst_i = rst_i; v.tok = tok; v.br = br; v.db = db;
        v.eop = eop; v.crc = crc; v.rd = rd;
        v.e_avail = ea; v.e_count = ec; v.e_data = ed;
        v.e_last = el; v.e_ovf = eo; v.e_drop = edr;
        return v;
    endfunction

    logic [7:0] exp_seq [5];
    logic [7:0] got_data[$];
    logic       got_last[$];
    int         max_count;

    initial begin
        n_rst = 1'b0; out_token = 1'b0; byte_ready = 1'b0; data_byte = 8'h00;
        eop_found = 1'b0; crc_err = 1'b0; rd_en = 1'b0;

        //            rst tok br  db     eop crc rd   avail cnt          data                  last ovf drop
        vecs[0]  = mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 8'hC3, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 8'hAA, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[4]  = mk(1, 0, 1, 8'hBB, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8'h00, 1, 0, 0,   TZ, 4'(TZ),     TZ ? 8'hAA : 8'h00,   0, 0, !TZ);
        vecs[6]  = mk(1, 0, 0, 8'h00, 0, 0, 1,   TZ, 4'(TZ),     TZ ? 8'hBB : 8'h00,   TZ, 0, 0);
        vecs[7]  = mk(1, 0, 0, 8'h00, 0, 0, 1,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 8'h00, 0, 0, 1,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[9]  = mk(1, 1, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[10] = mk(1, 0, 1, 8'hC3, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[11] = mk(1, 0, 1, 8'h55, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[12] = mk(1, 0, 0, 8'h00, 0, 1, 0,   0, 4'd0,        8'h00,                0, 0, 1);
        vecs[13] = mk(1, 0, 0, 8'h00, 1, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[14] = mk(1, 0, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[15] = mk(1, 1, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[16] = mk(1, 0, 1, 8'hC3, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[17] = mk(1, 0, 0, 8'h00, 1, 0, 0,   0, 4'd0,        8'h00,                0, 0, 1);
        vecs[18] = mk(1, 0, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[19] = mk(1, 1, 0, 8'h00, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[20] = mk(1, 0, 0, 8'h00, 1, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[21] = mk(1, 0, 1, 8'h77, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[22] = mk(1, 0, 1, 8'h78, 0, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);
        vecs[23] = mk(1, 0, 0, 8'h00, 1, 0, 0,   0, 4'd0,        8'h00,                0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst_i, vecs[i].tok, vecs[i].br, vecs[i].db,
                 vecs[i].eop, vecs[i].crc, vecs[i].rd);
            check($sformatf("vec%0d.avail", i), 32'(pkt_avail),   32'(vecs[i].e_avail));
            check($sformatf("vec%0d.count", i), 32'(pkt_count),   32'(vecs[i].e_count));
            check($sformatf("vec%0d.data", i),  32'(rd_data),     32'(vecs[i].e_data));
            check($sformatf("vec%0d.last", i),  32'(rd_last),     32'(vecs[i].e_last));
            check($sformatf("vec%0d.ovf", i),   32'(overflow),    32'(vecs[i].e_ovf));
            check($sformatf("vec%0d.drop", i),  32'(pkt_dropped), 32'(vecs[i].e_drop));
        end

        // Basic packet: C3,11,22,33,AA,BB then pop everything.
        cur_tag = "basic";
        do_reset();
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB};
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        for (int i = 0; i < 5; i++) drv(0, 1, exp_seq[i], 0, 0, 0);
        drv(0, 0, 8'h00, 1, 0, 0);
        check("basic.count_after_commit", 32'(pkt_count), 32'd1);
        for (int i = 0; i < 5 - T; i++) begin
            check($sformatf("basic.pop%0d.data", i), 32'(rd_data), 32'(exp_seq[i]));
            check($sformatf("basic.pop%0d.last", i), 32'(rd_last), 32'(i == 4 - T));
            drv(0, 0, 8'h00, 0, 0, 1);
        end
        check("basic.empty_after_pops", 32'(pkt_avail), 32'd0);

        // Overflow: 6-byte packet committed, second packet overflows on its 3rd byte.
        cur_tag = "ovf";
        do_reset();
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        for (int i = 1; i <= 6; i++) drv(0, 1, 8'(i), 0, 0, 0);
        for (int k = 0; k < T; k++) drv(0, 1, 8'(224 + k), 0, 0, 0);
        drv(0, 0, 8'h00, 1, 0, 0);
        check("ovf.count_first", 32'(pkt_count), 32'd1);
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        drv(0, 1, 8'h0A, 0, 0, 0);
        drv(0, 1, 8'h0B, 0, 0, 0);
        check("ovf.no_pulse_before_full", 32'(overflow), 32'd0);
        drv(0, 1, 8'h0C, 0, 0, 0);
        check("ovf.pulse", 32'(overflow), 32'd1);
        drv(0, 0, 8'h00, 0, 0, 0);
        check("ovf.pulse_one_cycle", 32'(overflow), 32'd0);
        drv(0, 0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ovf.read%0d.data", i), 32'(rd_data), 32'(i + 1));
            check($sformatf("ovf.read%0d.last", i), 32'(rd_last), 32'(i == 5));
            drv(0, 0, 8'h00, 0, 0, 1);
        end
        check("ovf.drained", 32'(pkt_avail), 32'd0);

        // Byte arriving when full, with a pop in the same cycle: still overflows.
        cur_tag = "fullpop";
        do_reset();
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        for (int i = 1; i <= 6; i++) drv(0, 1, 8'(16 + i), 0, 0, 0);
        for (int k = 0; k < T; k++) drv(0, 1, 8'(224 + k), 0, 0, 0);
        drv(0, 0, 8'h00, 1, 0, 0);
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        drv(0, 1, 8'h07, 0, 0, 0);
        drv(0, 1, 8'h08, 0, 0, 0);
        drv(0, 1, 8'h09, 0, 0, 1);
        check("fullpop.ovf", 32'(overflow), 32'd1);
        drv(0, 0, 8'h00, 1, 0, 0);

        // Pointer wrap: 20 packets of 5 payload bytes with reads always enabled.
        cur_tag = "wrap";
        do_reset();
        max_count = 0;
        for (int p = 0; p < 20; p++) begin
            for (int s = 0; s < 8 + T; s++) begin
                logic tk, br, eo;
                logic [7:0] db;
                tk = (s == 0);
                br = (s >= 1) && (s <= 6 + T);
                eo = (s == 7 + T);
                db = (s == 1) ? 8'hC3 : (s <= 6) ? 8'(p * 5 + s - 2) : 8'hEE;
                if (pkt_avail) begin
                    got_data.push_back(rd_data);
                    got_last.push_back(rd_last);
                end
                drv(tk, br, db, eo, 0, 1);
                if (int'(pkt_count) > max_count) max_count = int'(pkt_count);
            end
        end
        for (int s = 0; s < 8; s++) begin
            if (pkt_avail) begin
                got_data.push_back(rd_data);
                got_last.push_back(rd_last);
            end
            drv(0, 0, 8'h00, 0, 0, 1);
        end
        check("wrap.bytes_read", 32'(got_data.size()), 32'd100);
        for (int k = 0; k < got_data.size() && k < 100; k++) begin
            check($sformatf("wrap.byte%0d.data", k), 32'(got_data[k]), 32'(k));
            check($sformatf("wrap.byte%0d.last", k), 32'(got_last[k]), 32'(k % 5 == 4));
        end
        check("wrap.max_count", 32'(max_count), 32'd1);

        // out_token aborts a packet in flight; out_token beats a simultaneous eop.
        cur_tag = "abort";
        do_reset();
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        drv(0, 1, 8'hAA, 0, 0, 0);
        drv(0, 1, 8'hBB, 0, 0, 0);
        drv(1, 0, 8'h00, 0, 0, 0);
        check("abort.no_drop_pulse", 32'(pkt_dropped), 32'd0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        drv(0, 1, 8'h11, 0, 0, 0);
        drv(0, 1, 8'h22, 0, 0, 0);
        drv(0, 1, 8'h33, 0, 0, 0);
        drv(0, 0, 8'h00, 1, 0, 0);
        check("abort.first_byte", 32'(rd_data), 32'h11);
        check("abort.count", 32'(pkt_count), 32'd1);
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        drv(0, 1, 8'h44, 0, 0, 0);
        drv(1, 0, 8'h00, 1, 0, 0);
        check("tok_eop.count", 32'(pkt_count), 32'd1);
        drv(0, 0, 8'h00, 1, 0, 0);
        check("tok_eop.no_drop", 32'(pkt_dropped), 32'd0);

        // Reset in the middle of a packet with committed data present.
        cur_tag = "midreset";
        drv(1, 0, 8'h00, 0, 0, 0);
        drv(0, 1, 8'hC3, 0, 0, 0);
        drv(0, 1, 8'h55, 0, 0, 0);
        do_reset();
        check("midreset.avail", 32'(pkt_avail), 32'd0);
        check("midreset.count", 32'(pkt_count), 32'd0);
        check("midreset.data", 32'(rd_data), 32'd0);
        drv(0, 1, 8'h66, 0, 0, 0);
        drv(0, 1, 8'h77, 0, 0, 0);
        drv(0, 0, 8'h00, 1, 0, 0);
        check("midreset.idle_ignores", 32'(pkt_avail), 32'd0);

        // Randomized traffic against the model.
        cur_tag = "rand";
        for (int c = 0; c < 3000; c++) begin
            logic r, tk, br, eo, cr, rd;
            logic [7:0] db;
            r  = ($urandom_range(0, 399) != 0);
            tk = ($urandom_range(0, 24) == 0);
            eo = ($urandom_range(0, 7) == 0);
            br = !eo && ($urandom_range(0, 9) < 6);
            cr = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 9) < 4);
            db = 8'($urandom);
            step(r, tk, br, db, eo, cr, rd);
            check_model(cur_tag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
